// File: rtl/qcw_burst_ctrl.sv
// qcw_burst_ctrl: QCW burst sequencer feeding qcw_pll start/halt/phase_shift/cycle_limit.
// Define QCW_FAULT_RETRY_EN to leave FAULT automatically after FAULT_HOLDOFF clocks.
module qcw_burst_ctrl #(
   parameter int unsigned PHASE_W        = 8,
   parameter int unsigned PERIOD_W       = 24,
   parameter int unsigned MIN_OFF_CYCLES = 100000,
   parameter int unsigned WDOG_CYCLES    = 2000,
   parameter int unsigned FAULT_HOLDOFF  = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] burst_period,
   input  logic [15:0]         cycle_limit_cfg,
   input  logic [PHASE_W-1:0]  ramp_start,
   input  logic [PHASE_W-1:0]  ramp_end,
   input  logic [PHASE_W-1:0]  ramp_step,
   input  logic [7:0]          ramp_div,
   input  logic                pll_cycle_finished,
   input  logic                pll_fault,
   output logic                pll_start,
   output logic                pll_halt,
   output logic [PHASE_W-1:0]  phase_shift,
   output logic [15:0]         cycle_limit,
   output logic                busy,
   output logic                fault_latched,
   output logic [15:0]         burst_count
);
   localparam int unsigned WD_W   = $clog2(WDOG_CYCLES + 1);
   localparam int unsigned OFF_W  = $clog2(MIN_OFF_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(FAULT_HOLDOFF + 1);
`ifdef QCW_FAULT_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_FAULT} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_cf_q;
   logic [15:0]         r_cyc_cnt, w_cyc_nxt, w_cyc_inc;
   logic [7:0]          r_div_cnt, w_div_nxt, r_div_last, w_div_last_nxt;
   logic [WD_W-1:0]     r_wdog, w_wdog_nxt;
   logic [PERIOD_W-1:0] r_period_cnt, w_period_nxt, w_period_dec;
   logic [OFF_W-1:0]    r_off_cnt, w_off_nxt;
   logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
   logic [PHASE_W-1:0]  r_phase, w_phase_nxt, w_phase_step;
   logic [PHASE_W-1:0]  r_ramp_end, w_end_nxt, r_ramp_step, w_step_nxt;
   logic [PHASE_W:0]    w_sum, w_diff;
   logic [15:0]         r_cycle_limit, w_limit_nxt, r_burst_count, w_count_nxt;
   logic                r_pll_start, r_pll_halt, r_busy, r_fault;
   logic                w_edge, w_halt_pulse, w_wdog_exp, w_hold_exp;

   assign w_edge       = pll_cycle_finished & ~r_cf_q;
   assign w_cyc_inc    = r_cyc_cnt + 16'd1;
   assign w_period_dec = (r_period_cnt == '0) ? '0 : r_period_cnt - PERIOD_W'(1);
   assign w_wdog_exp   = (r_wdog == WD_W'(WDOG_CYCLES - 1));
   assign w_hold_exp   = (r_hold_cnt == HOLD_W'(FAULT_HOLDOFF - 1));

   // One ramp step toward ramp_end, computed one bit wider and clamped at the target
   always_comb begin
      w_sum  = {1'b0, r_phase} + {1'b0, r_ramp_step};
      w_diff = {1'b0, r_phase} - {1'b0, r_ramp_step};
      if (r_ramp_end >= r_phase)
         w_phase_step = (w_sum >= {1'b0, r_ramp_end}) ? r_ramp_end : w_sum[PHASE_W-1:0];
      else if (w_diff[PHASE_W] || (w_diff[PHASE_W-1:0] < r_ramp_end))
         w_phase_step = r_ramp_end;
      else
         w_phase_step = w_diff[PHASE_W-1:0];
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cyc_nxt      = r_cyc_cnt;
      w_div_nxt      = r_div_cnt;
      w_div_last_nxt = r_div_last;
      w_wdog_nxt     = r_wdog;
      w_period_nxt   = r_period_cnt;
      w_off_nxt      = r_off_cnt;
      w_hold_nxt     = '0;
      w_phase_nxt    = r_phase;
      w_end_nxt      = r_ramp_end;
      w_step_nxt     = r_ramp_step;
      w_limit_nxt    = r_cycle_limit;
      w_count_nxt    = r_burst_count;
      w_halt_pulse   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (pll_fault) begin
               w_state_nxt = ST_FAULT;
            end else if (enable) begin
               w_state_nxt    = ST_RUN;
               w_phase_nxt    = ramp_start;
               w_end_nxt      = ramp_end;
               w_step_nxt     = ramp_step;
               w_div_last_nxt = (ramp_div == 8'd0) ? 8'd0 : ramp_div - 8'd1;
               w_limit_nxt    = cycle_limit_cfg;
               w_cyc_nxt      = '0;
               w_div_nxt      = '0;
               w_wdog_nxt     = '0;
               w_period_nxt   = (burst_period == '0) ? '0 : burst_period - PERIOD_W'(1);
               w_count_nxt    = r_burst_count + 16'd1;
            end
         end
         ST_RUN: begin
            w_period_nxt = w_period_dec;
            w_off_nxt    = '0;
            if (w_edge) begin
               w_cyc_nxt  = w_cyc_inc;
               w_wdog_nxt = '0;
               if (r_div_cnt == r_div_last) begin
                  w_div_nxt   = '0;
                  w_phase_nxt = w_phase_step;
               end else begin
                  w_div_nxt = r_div_cnt + 8'd1;
               end
            end else if (!w_wdog_exp) begin
               w_wdog_nxt = r_wdog + WD_W'(1);
            end
            if (pll_fault || (!w_edge && w_wdog_exp)) begin
               w_state_nxt = ST_FAULT;
            end else if (!enable) begin
               w_state_nxt  = ST_DONE;
               w_halt_pulse = 1'b1;
            end else if ((r_cycle_limit == 16'd0) || (w_edge && (w_cyc_inc == r_cycle_limit))) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_period_nxt = w_period_dec;
            if (r_off_cnt != OFF_W'(MIN_OFF_CYCLES))
               w_off_nxt = r_off_cnt + OFF_W'(1);
            // Leave one clock early so the IDLE hop lands the next start on the period
            if (pll_fault)
               w_state_nxt = ST_FAULT;
            else if ((w_period_dec == '0) && (r_off_cnt >= OFF_W'(MIN_OFF_CYCLES)))
               w_state_nxt = ST_IDLE;
         end
         ST_FAULT: begin
            if (!pll_fault && !w_hold_exp)
               w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            if (!pll_fault && (!enable || (RETRY_EN && w_hold_exp)))
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cf_q        <= 1'b0;
         r_cyc_cnt     <= '0;
         r_div_cnt     <= '0;
         r_div_last    <= '0;
         r_wdog        <= '0;
         r_period_cnt  <= '0;
         r_off_cnt     <= '0;
         r_hold_cnt    <= '0;
         r_phase       <= '0;
         r_ramp_end    <= '0;
         r_ramp_step   <= '0;
         r_cycle_limit <= '0;
         r_burst_count <= '0;
         r_pll_start   <= 1'b0;
         r_pll_halt    <= 1'b0;
         r_busy        <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cf_q        <= pll_cycle_finished;
         r_cyc_cnt     <= w_cyc_nxt;
         r_div_cnt     <= w_div_nxt;
         r_div_last    <= w_div_last_nxt;
         r_wdog        <= w_wdog_nxt;
         r_period_cnt  <= w_period_nxt;
         r_off_cnt     <= w_off_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_phase       <= w_phase_nxt;
         r_ramp_end    <= w_end_nxt;
         r_ramp_step   <= w_step_nxt;
         r_cycle_limit <= w_limit_nxt;
         r_burst_count <= w_count_nxt;
         r_pll_start   <= (w_state_nxt == ST_RUN);
         r_busy        <= (w_state_nxt == ST_RUN);
         r_fault       <= (w_state_nxt == ST_FAULT);
         r_pll_halt    <= (w_state_nxt == ST_FAULT) || w_halt_pulse;
      end
   end

   assign pll_start     = r_pll_start;
   assign pll_halt      = r_pll_halt;
   assign phase_shift   = r_phase;
   assign cycle_limit   = r_cycle_limit;
   assign busy          = r_busy;
   assign fault_latched = r_fault;
   assign burst_count   = r_burst_count;
endmodule

// File: tb/tb_qcw_burst_ctrl.sv
// Directed bench for qcw_burst_ctrl: reset, ramps, period, watchdog, fault priority, abort.
`timescale 1ns/1ps
module tb_qcw_burst_ctrl;
   localparam int unsigned PHASE_W  = 8;
   localparam int unsigned PERIOD_W = 24;
   localparam int unsigned MIN_OFF  = 1000;
   localparam int unsigned WDOG     = 2000;
   localparam int unsigned HOLDOFF  = 500;

   logic                clk = 1'b0;
   logic                rst, enable, pll_cycle_finished, pll_fault;
   logic [PERIOD_W-1:0] burst_period;
   logic [15:0]         cycle_limit_cfg;
   logic [PHASE_W-1:0]  ramp_start, ramp_end, ramp_step;
   logic [7:0]          ramp_div;
   logic                pll_start, pll_halt, busy, fault_latched;
   logic [PHASE_W-1:0]  phase_shift;
   logic [15:0]         cycle_limit, burst_count;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned cyc = 0;

   qcw_burst_ctrl #(
      .PHASE_W(PHASE_W), .PERIOD_W(PERIOD_W), .MIN_OFF_CYCLES(MIN_OFF),
      .WDOG_CYCLES(WDOG), .FAULT_HOLDOFF(HOLDOFF)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .burst_period(burst_period),
      .cycle_limit_cfg(cycle_limit_cfg), .ramp_start(ramp_start), .ramp_end(ramp_end),
      .ramp_step(ramp_step), .ramp_div(ramp_div), .pll_cycle_finished(pll_cycle_finished),
      .pll_fault(pll_fault), .pll_start(pll_start), .pll_halt(pll_halt),
      .phase_shift(phase_shift), .cycle_limit(cycle_limit), .busy(busy),
      .fault_latched(fault_latched), .burst_count(burst_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Raise cycle_finished and step to the negedge after the edge is registered
   task automatic rf_rise();
      pll_cycle_finished = 1'b1;
      @(negedge clk);
   endtask

   task automatic rf_fall_wait();
      repeat (299) @(negedge clk);
      pll_cycle_finished = 1'b0;
      repeat (300) @(negedge clk);
   endtask

   initial begin
      int unsigned t0, k, exp_ph;
      logic seen;
      rst = 1'b1; enable = 1'b0; pll_cycle_finished = 1'b0; pll_fault = 1'b0;
      burst_period = '0; cycle_limit_cfg = '0;
      ramp_start = '0; ramp_end = '0; ramp_step = '0; ramp_div = '0;
      repeat (3) @(negedge clk);
      check("rst_start", pll_start, 0);
      check("rst_halt", pll_halt, 0);
      check("rst_phase", phase_shift, 0);
      check("rst_limit", cycle_limit, 0);
      check("rst_busy", busy, 0);
      check("rst_fault", fault_latched, 0);
      check("rst_count", burst_count, 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (pll_start) seen = 1'b1;
      end
      check("idle_no_start", seen, 0);

      // Ramp up 10->40 step 7, two RF cycles per step, 20-cycle burst
      ramp_start = 8'd10; ramp_end = 8'd40; ramp_step = 8'd7; ramp_div = 8'd2;
      cycle_limit_cfg = 16'd20; burst_period = 24'd1;
      enable = 1'b1;
      @(negedge clk);
      check("up_start", pll_start, 1);
      check("up_busy", busy, 1);
      check("up_phase0", phase_shift, 10);
      check("up_limit", cycle_limit, 20);
      check("up_count", burst_count, 1);
      for (int n = 1; n <= 20; n++) begin
         rf_rise();
         exp_ph = 10 + 7 * (n / 2);
         if (exp_ph > 40) exp_ph = 40;
         check("up_phase", phase_shift, exp_ph);
         check("up_start_n", pll_start, n < 20);
         check("up_busy_n", busy, n < 20);
         if (n == 20) begin
            check("up_no_halt", pll_halt, 0);
            enable = 1'b0;
         end
         rf_fall_wait();
      end
      repeat (600) @(negedge clk);

      // Ramp down 200->150 step 30, div 0 treated as 1; 5000-clk burst period
      ramp_start = 8'd200; ramp_end = 8'd150; ramp_step = 8'd30; ramp_div = 8'd0;
      cycle_limit_cfg = 16'd3; burst_period = 24'd5000;
      enable = 1'b1;
      @(negedge clk);
      t0 = cyc;
      check("dn_start", pll_start, 1);
      check("dn_count", burst_count, 2);
      check("dn_phase0", phase_shift, 200);
      for (int n = 1; n <= 3; n++) begin
         rf_rise();
         check("dn_phase", phase_shift, (n == 1) ? 170 : 150);
         check("dn_start_n", pll_start, n < 3);
         rf_fall_wait();
      end
      seen = 1'b0;
      for (int i = 0; i < 10000 && !seen; i++) begin
         @(negedge clk);
         if (pll_start) seen = 1'b1;
      end
      check("dn_rise2_seen", seen, 1);
      check("dn_period", cyc - t0, 5000);
      check("dn_count2", burst_count, 3);
      check("dn_phase2", phase_shift, 200);

      // Stall: new config must not affect the running burst; watchdog trips
      ramp_start = 8'd10; ramp_end = 8'd40; ramp_step = 8'd7; ramp_div = 8'd2;
      cycle_limit_cfg = 16'd20; burst_period = 24'd1;
      rf_rise();
      check("wd_phase_latched", phase_shift, 170);
      pll_cycle_finished = 1'b0;
      k = 0; seen = 1'b0;
      while (!seen && k < 3000) begin
         @(negedge clk);
         k++;
         if (fault_latched) seen = 1'b1;
      end
      check("wd_seen", seen, 1);
      check("wd_delay", k, WDOG);
      check("wd_halt", pll_halt, 1);
      check("wd_start", pll_start, 0);
      check("wd_busy", busy, 0);
      enable = 1'b0;
      @(negedge clk);
      check("wd_clr_fault", fault_latched, 0);
      check("wd_clr_halt", pll_halt, 0);
      enable = 1'b1;
      @(negedge clk);
      check("ab_start", pll_start, 1);
      check("ab_count", burst_count, 4);
      check("ab_phase0", phase_shift, 10);

      // Abort at edge 5 of 20
      for (int n = 1; n <= 5; n++) begin
         if (n == 5) enable = 1'b0;
         rf_rise();
         check("ab_phase", phase_shift, 10 + 7 * (n / 2));
         if (n == 5) begin
            check("ab_halt", pll_halt, 1);
            check("ab_start_lo", pll_start, 0);
            check("ab_busy_lo", busy, 0);
            @(negedge clk);
            check("ab_halt_pulse", pll_halt, 0);
         end
         rf_fall_wait();
      end
      cycle_limit_cfg = 16'd2;
      repeat (1100) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      check("pf_start", pll_start, 1);
      check("pf_count", burst_count, 5);
      check("pf_limit", cycle_limit, 2);

      // pll_fault on the final limit edge wins over completion
      rf_rise();
      rf_fall_wait();
      pll_fault = 1'b1;
      rf_rise();
      pll_fault = 1'b0;
      check("pf_fault", fault_latched, 1);
      check("pf_halt", pll_halt, 1);
      check("pf_start_lo", pll_start, 0);
      check("pf_busy_lo", busy, 0);
`ifdef QCW_FAULT_RETRY_EN
      pll_cycle_finished = 1'b0;
      k = 0; seen = 1'b0;
      while (!seen && k < 2000) begin
         @(negedge clk);
         k++;
         if (!fault_latched) seen = 1'b1;
      end
      check("rt_seen", seen, 1);
      check("rt_holdoff", k, HOLDOFF + 1);
      check("rt_halt", pll_halt, 0);
      @(negedge clk);
      check("rt_start", pll_start, 1);
      check("rt_count", burst_count, 6);
`else
      rf_fall_wait();
      check("pf_hold_fault", fault_latched, 1);
      check("pf_hold_halt", pll_halt, 1);
      enable = 1'b0;
      @(negedge clk);
      check("pf_clr_fault", fault_latched, 0);
      check("pf_clr_halt", pll_halt, 0);
      check("pf_count_kept", burst_count, 5);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
